// File: rtl/random_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : random_range_sampler
// Purpose  : Draws a uniformly distributed value in [0, N-1] from a
//            free-running LFSR using masked rejection sampling. After
//            MAX_TRIES rejected candidates the last candidate is folded
//            into range by subtracting N. The result is held on a
//            valid/ready handshake until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module random_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lfsr_data,
    input  logic [WIDTH-1:0] range_n,
    input  logic             req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value,
    output logic             fallback
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MASK   = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       c_last_try = 8'(MAX_TRIES - 1);

    state_t           r_state;
    state_t           w_state_next;

    // Range size kept one bit wider so that N = 2^WIDTH is representable.
    logic [WIDTH:0]   r_n_reg;
    logic [WIDTH-1:0] r_mask;
    logic [7:0]       r_tries;
    logic [WIDTH-1:0] r_value;
    logic             r_fallback;

    logic [WIDTH:0]   w_n_latched;
    logic [WIDTH-1:0] w_mask_seed;
    logic [WIDTH-1:0] w_mask_smear;
    logic [WIDTH-1:0] w_cand_raw;
    logic [WIDTH:0]   w_cand;
    logic [WIDTH-1:0] w_fold;
    logic             w_accept;
    logic             w_last_try;

    // range_n == 0 encodes the full 2^WIDTH range.
    assign w_n_latched = (range_n == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, range_n};

    // N-1 fits in WIDTH bits; when N = 2^WIDTH it is simply all ones.
    assign w_mask_seed = r_n_reg[WIDTH] ? {WIDTH{1'b1}} : (r_n_reg[WIDTH-1:0] - c_one);

    assign w_cand_raw  = lfsr_data & r_mask;
    assign w_cand      = {1'b0, w_cand_raw};
    assign w_accept    = (w_cand < r_n_reg);
    assign w_last_try  = (r_tries == c_last_try);

    // The fold is only used when cand >= N, so N < 2^WIDTH there and the
    // WIDTH-bit difference equals the truncated WIDTH+1 bit difference.
    assign w_fold      = w_cand_raw - r_n_reg[WIDTH-1:0];

    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_HOLD);
    assign value       = r_value;
    assign fallback    = r_fallback;

    // Smear the highest set bit of N-1 downward to get the smallest 2^k-1 >= N-1.
    always_comb begin
        w_mask_smear = w_mask_seed;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask_smear = w_mask_smear | (w_mask_smear >> 1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: sample, retry until accept or retry budget exhausted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (req) w_state_next = S_MASK;
            S_MASK:   w_state_next = S_SAMPLE;
            S_SAMPLE: if (w_accept || w_last_try) w_state_next = S_HOLD;
            S_HOLD:   if (out_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch range, build mask, count retries, capture the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_reg    <= '0;
            r_mask     <= '0;
            r_tries    <= '0;
            r_value    <= '0;
            r_fallback <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_n_reg <= w_n_latched;
                    end
                end
                S_MASK: begin
                    r_mask  <= w_mask_smear;
                    r_tries <= '0;
                end
                S_SAMPLE: begin
                    if (w_accept) begin
                        r_value    <= w_cand_raw;
                        r_fallback <= 1'b0;
                    end else if (w_last_try) begin
                        r_value    <= w_fold;
                        r_fallback <= 1'b1;
                    end else begin
                        r_tries <= r_tries + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_random_range_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_random_range_sampler
// Purpose  : Self-checking bench for random_range_sampler: reset, handshake,
//            table vectors, randomized draws against a reference model and
//            draws fed by a Fibonacci 16-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_range_sampler;

    localparam int WIDTH     = 16;
    localparam int MAX_TRIES = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  lfsr_data;
    logic [WIDTH-1:0]  range_n;
    logic              req;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  value;
    logic              fallback;

    int                errors = 0;
    int                checks = 0;

    // Data presented at sample attempt t (edge E2+t); last entry is held.
    logic [15:0]       dq [8];
    logic [15:0]       lfsr_state = 16'hACE1;
    bit                use_lfsr   = 1'b0;

    typedef struct {
        logic [15:0]       n;
        logic [3:0][15:0]  d;
        logic [15:0]       v;
        logic              fb;
        int                lat;
    } vec_t;

    vec_t vecs [10];

    random_range_sampler #(.WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES)) dut (
        .clk       (clk),
        .rst       (rst),
        .lfsr_data (lfsr_data),
        .range_n   (range_n),
        .req       (req),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .fallback  (fallback)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Present data for sample attempt t (t < 0: the cycles before sampling).
    task automatic drive_data(input int t);
        if (use_lfsr) begin
            lfsr_state = lfsr_next(lfsr_state);
            lfsr_data  = lfsr_state;
            if (t >= 0 && t < 8) dq[t] = lfsr_state;
        end else if (t < 0) begin
            lfsr_data = 16'($urandom);
        end else begin
            lfsr_data = dq[(t < 8) ? t : 7];
        end
    endtask

    // Reference: rejection sampling over the data sequence dq.
    task automatic model(input logic [15:0] n_in, output logic [15:0] v,
                         output logic fb, output int lat);
        int n;
        int mask;
        int cand;
        n    = (n_in == 16'd0) ? 65536 : int'(n_in);
        mask = 0;
        while (mask < n - 1) mask = mask * 2 + 1;
        v = '0; fb = 1'b0; lat = 0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            cand = int'(dq[t]) & mask;
            if (cand < n) begin
                v = 16'(cand); fb = 1'b0; lat = 2 + t;
                return;
            end
            if (t == MAX_TRIES - 1) begin
                v = 16'(cand - n); fb = 1'b1; lat = 2 + t;
            end
        end
    endtask

    // Issue a request from IDLE and wait until out_valid; lat = edge index.
    task automatic start_draw(input logic [15:0] n, output int lat);
        range_n = n;
        req     = 1'b1;
        drive_data(-1);
        tick();                                   // E0
        req     = 1'b0;
        range_n = 16'($urandom);                  // must not affect the draw
        check1("busy_after_E0", busy, 1'b1);
        drive_data(-1);
        tick();                                   // E1
        lat = -1;
        for (int k = 2; k <= 20 && lat < 0; k++) begin
            drive_data(k - 2);
            tick();
            if (out_valid) lat = k;
        end
        if (lat < 0) check1("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic finish_draw(input string tag, input logic [15:0] ev, input logic efb,
                               input int elat, input int lat);
        check16({tag, "_value"}, value, ev);
        check1({tag, "_fallback"}, fallback, efb);
        checki({tag, "_latency"}, lat, elat);
        out_ready = 1'b1;
        tick();
        check1({tag, "_valid_after_accept"}, out_valid, 1'b0);
        check1({tag, "_busy_after_accept"}, busy, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ev;
        logic        efb;
        int          elat;
        int          lat;
        int          cnt;
        logic [15:0] n;

        vecs[0] = '{16'd10,     {16'h0007, 16'h0007, 16'h0007, 16'h0007}, 16'd7,     1'b0, 2};
        vecs[1] = '{16'd10,     {16'h0023, 16'h0023, 16'h001F, 16'h000C}, 16'd3,     1'b0, 4};
        vecs[2] = '{16'd10,     {16'h000E, 16'h000E, 16'h000E, 16'h000E}, 16'd4,     1'b1, 9};
        vecs[3] = '{16'd0,      {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF}, 16'hBEEF,  1'b0, 2};
        vecs[4] = '{16'd1,      {16'h1234, 16'h1234, 16'h1234, 16'h1234}, 16'd0,     1'b0, 2};
        vecs[5] = '{16'h8001,   {16'h0005, 16'h0005, 16'h0005, 16'hFFFF}, 16'd5,     1'b0, 3};
        vecs[6] = '{16'h8001,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h7FFE,  1'b1, 9};
        vecs[7] = '{16'hFFFF,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'd0,     1'b1, 9};
        vecs[8] = '{16'd16,     {16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD}, 16'd13,    1'b0, 2};
        vecs[9] = '{16'd2,      {16'h0003, 16'h0003, 16'h0003, 16'h0003}, 16'd1,     1'b0, 2};

        // Power-on reset with req asserted: req must be ignored.
        rst = 1'b1; req = 1'b1; out_ready = 1'b0; range_n = 16'd10; lfsr_data = 16'h0;
        tick(); tick();
        check1("reset_valid", out_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check16("reset_value", value, 16'h0);
        check1("reset_fallback", fallback, 1'b0);
        rst = 1'b0; req = 1'b0;
        tick();
        check1("reset_req_ignored", busy, 1'b0);

        // Handshake: hold result with out_ready low, req pulses ignored.
        for (int t = 0; t < 8; t++) dq[t] = 16'h0007;
        start_draw(16'd10, lat);
        checki("hs_latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            req       = c[0];
            lfsr_data = 16'($urandom);
            range_n   = 16'($urandom);
            tick();
            check1($sformatf("hs_hold_valid_%0d", c), out_valid, 1'b1);
            check1($sformatf("hs_hold_busy_%0d", c), busy, 1'b1);
            check16($sformatf("hs_hold_value_%0d", c), value, 16'd7);
        end
        req = 1'b1; out_ready = 1'b1;   // req in the consuming HOLD cycle is ignored too
        tick();
        check1("hs_release_valid", out_valid, 1'b0);
        check1("hs_release_busy", busy, 1'b0);
        req = 1'b0; out_ready = 1'b0;
        tick();
        check1("hs_idle_stays", busy, 1'b0);

        // Reset while in HOLD clears a nonzero result.
        start_draw(16'd10, lat);
        rst = 1'b1; req = 1'b1;
        tick(); tick();
        check1("rst_hold_valid", out_valid, 1'b0);
        check1("rst_hold_busy", busy, 1'b0);
        check16("rst_hold_value", value, 16'h0);
        rst = 1'b0; req = 1'b0;
        tick();
        check1("rst_hold_req_ignored", busy, 1'b0);

        // Reset mid-SAMPLE during a long reject run.
        range_n = 16'd10; req = 1'b1; lfsr_data = 16'h000E;
        tick(); req = 1'b0;
        tick(); tick(); tick();
        check1("pre_rst_sample_busy", busy, 1'b1);
        rst = 1'b1; req = 1'b1;
        tick(); tick();
        check1("rst_sample_valid", out_valid, 1'b0);
        check1("rst_sample_busy", busy, 1'b0);
        check1("rst_sample_fallback", fallback, 1'b0);
        rst = 1'b0; req = 1'b0;
        tick();
        check1("rst_sample_req_ignored", busy, 1'b0);

        // Table vectors with hand-derived results.
        for (int i = 0; i < 10; i++) begin
            for (int t = 0; t < 8; t++) dq[t] = vecs[i].d[(t < 4) ? t : 3];
            start_draw(vecs[i].n, lat);
            finish_draw($sformatf("vec%0d", i), vecs[i].v, vecs[i].fb, vecs[i].lat, lat);
        end

        // Back-to-back throughput with req and out_ready held high.
        req = 1'b1; out_ready = 1'b1; range_n = 16'd10; lfsr_data = 16'h0007;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        checki("throughput_results_in_16", cnt, 4);
        req = 1'b0;
        tick(); tick(); tick(); tick();
        out_ready = 1'b0;
        check1("throughput_drained", busy, 1'b0);

        // Randomized draws against the reference model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       n = 16'd0;
                1:       n = 16'($urandom_range(1, 20));
                2:       n = 16'($urandom);
                default: n = 16'h8000 + 16'($urandom_range(0, 15));
            endcase
            for (int t = 0; t < 8; t++) dq[t] = 16'($urandom);
            model(n, ev, efb, elat);
            out_ready = 1'($urandom_range(0, 1));
            start_draw(n, lat);
            finish_draw($sformatf("rnd%0d", i), ev, efb, elat, lat);
        end

        // Draws fed by a free-running many-to-one LFSR, N = 6.
        use_lfsr = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            start_draw(16'd6, lat);
            model(16'd6, ev, efb, elat);
            check1($sformatf("lfsr%0d_in_range", i), value < 16'd6, 1'b1);
            finish_draw($sformatf("lfsr%0d", i), ev, efb, elat, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
